// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the issue-entry record held by the
// main and skid registers of the ALU issue stage.
package rv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [2:0]  op;
        logic        qual;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
        logic [31:0] pc;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decoder for the OP, OP-IMM, LUI and AUIPC classes,
// producing one ALU issue entry per instruction.
module alu_issue_decode
    import rv_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic [31:0]  pc,
    input  logic [31:0]  rs1,
    input  logic [31:0]  rs2,
    output issue_entry_t entry
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        entry = '0;
        legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                entry.in1 = rs1;
                entry.in2 = rs2;
                entry.op  = funct3;
                entry.qual = instr[30];
                legal = (funct7 == FUNCT7_BASE) ||
                        ((funct7 == FUNCT7_ALT) && ((funct3 == ALU_ADD) || (funct3 == ALU_SRL)));
            end
            OPC_OP_IMM: begin
                entry.in1 = rs1;
                entry.in2 = {{20{instr[31]}}, instr[31:20]};
                entry.op  = funct3;
                // Only the right shift uses bit 30 as a qualifier; ADDI must never subtract
                entry.qual = (funct3 == ALU_SRL) ? instr[30] : 1'b0;
                if (funct3 == ALU_SLL)
                    legal = (funct7 == FUNCT7_BASE);
                else if (funct3 == ALU_SRL)
                    legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                else
                    legal = 1'b1;
            end
            OPC_LUI: begin
                entry.in2 = {instr[31:12], 12'b0};
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                entry.in1 = pc;
                entry.in2 = {instr[31:12], 12'b0};
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            entry.in1  = '0;
            entry.in2  = '0;
            entry.op   = ALU_ADD;
            entry.qual = 1'b0;
        end

        entry.rd      = instr[11:7];
        entry.rd_we   = legal && (instr[11:7] != 5'd0);
        entry.illegal = !legal;
        entry.pc      = pc;
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction and holds it in a registered
// output slot backed by one skid entry so in_ready_o is fully registered.
module alu_issue
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] alu_in1_o,
    output logic [XLEN-1:0] alu_in2_o,
    output logic [2:0]      alu_op_o,
    output logic            alu_op_qual_o,
    output logic [4:0]      rd_o,
    output logic            rd_we_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] pc_o
);

    issue_entry_t dec_entry;
    issue_entry_t main_q;
    issue_entry_t skid_q;
    logic         main_valid;
    logic         skid_valid;
    logic         in_fire;
    logic         main_free;

    alu_issue_decode u_decode (
        .instr (instr_i),
        .pc    (pc_i),
        .rs1   (rs1_data_i),
        .rs2   (rs2_data_i),
        .entry (dec_entry)
    );

    assign in_ready_o = ~skid_valid;
    assign in_fire    = in_valid_i & in_ready_o;
    assign main_free  = ~main_valid | out_ready_i;

    // A waiting skid entry always refills main before any new input, keeping order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_fire;
                if (in_fire)
                    main_q <= dec_entry;
            end
        end else if (in_fire) begin
            skid_q     <= dec_entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid_o   = main_valid;
    assign alu_in1_o     = main_q.in1;
    assign alu_in2_o     = main_q.in2;
    assign alu_op_o      = main_q.op;
    assign alu_op_qual_o = main_q.qual;
    assign rd_o          = main_q.rd;
    assign rd_we_o       = main_q.rd_we;
    assign illegal_o     = main_q.illegal;
    assign pc_o          = main_q.pc;

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Execute-issue stage directly upstream of the integer ALU.
- Accepts a fetched RV32I instruction plus its register-file operands and PC, and decodes the OP, OP-IMM, LUI and AUIPC classes.
- Drives the ALU's two 32-bit operands, 3-bit operation code and op-qualifier bit from a registered output.
- Valid/ready on both sides with a 2-entry skid buffer, so the ready path is fully registered.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous kill of all buffered entries
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  this block can accept an entry
- instr_i  in  32  instruction word
- pc_i  in  32  instruction address
- rs1_data_i  in  32  register-file value of rs1
- rs2_data_i  in  32  register-file value of rs2
- out_valid_o  out  1  ALU issue entry valid
- out_ready_i  in  1  downstream consumes the entry
- alu_in1_o  out  32  ALU operand 1
- alu_in2_o  out  32  ALU operand 2
- alu_op_o  out  3  ALU operation code (funct3 encoding)
- alu_op_qual_o  out  1  0 = add / logical shift; 1 = subtract / arithmetic shift
- rd_o  out  5  destination register
- rd_we_o  out  1  write-back enable
- illegal_o  out  1  entry is an unsupported or illegal encoding
- pc_o  out  32  PC of the issued entry

Behaviour:
- Reset (async assert, sync deassert): out_valid_o=0, in_ready_o=1, skid entry invalid. All data outputs reset to 0: alu_in1_o, alu_in2_o, alu_op_o, alu_op_qual_o, rd_o, rd_we_o, illegal_o, pc_o.
- Decode is combinational on the input side. The result is written into the main (output) register, or into the skid register when the main register is occupied and stalled.
- Latency: an accepted entry appears on the outputs on the next cycle. With out_ready_i held at 1, throughput is 1 entry per cycle.
- Handshake transfer rules:
  - Input transfers when in_valid_i & in_ready_o.
  - Output transfers when out_valid_o & out_ready_i.
  - Output fields hold stable while out_valid_o=1 and out_ready_i=0.
- in_ready_o is a register equal to "skid register empty". It deasserts the cycle after an input is accepted while output is valid and stalled.
- Ordering:
  - When the output drains and the skid register is full, skid moves to main and an in-flight input is not accepted that cycle; in_ready_o rises next cycle.
  - When the output drains, the skid register is empty and an input arrives, the input loads main directly.
  - Entries are never lost, duplicated or reordered.
- flush_i: on the next edge both entries are invalid and in_ready_o=1. Any input presented in the flush cycle is dropped. Flush takes priority over all simultaneous transfers.
- Decode by opcode instr[6:0]:
  - OP (0110011): in1=rs1, in2=rs2, op=funct3, qual=instr[30]. Legal only if funct7=0000000, or funct7=0100000 with funct3 000 or 101.
  - OP-IMM (0010011): in1=rs1, in2=sign-extended instr[31:20], op=funct3.
    - qual=instr[30] only for funct3=101; qual=0 otherwise, so ADDI never subtracts.
    - funct3=001 legal only with instr[31:25]=0000000.
    - funct3=101 legal only with instr[31:25] equal to 0000000 or 0100000.
  - LUI (0110111): in1=0, in2={instr[31:12],12'b0}, op=000, qual=0.
  - AUIPC (0010111): in1=pc_i, in2={instr[31:12],12'b0}, op=000, qual=0.
  - Anything else, or an illegal funct field: illegal_o=1, in1=in2=0, op=000, qual=0, rd_we_o=0.
- rd_o=instr[11:7] in all cases. rd_we_o = legal & (rd != 0).
- pc_o is pc_i carried through unchanged.

Decomposition:
- Shared package (rv_pkg): opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC), funct3 ALU constants (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND), and a packed issue-entry struct {in1, in2, op, qual, rd, rd_we, illegal, pc} used by both the main and skid registers.
- One sub-module, alu_issue_decode: a purely combinational decoder taking instr, pc, rs1 and rs2 and producing the entry struct. The parent holds only the skid/handshake logic.

Test Plan:
- Reset, then issue 0x40208033 (sub x0? no: rd=0 check) with rs1=5, rs2=3 and out_ready=1 -> one cycle later out_valid=1, op=000, qual=1, in1=5, in2=3, rd_we=0 because rd=x0.
- ADDI x1,x2,-1 (0xFFF10093), rs1=10 -> in2=0xFFFFFFFF, op=000, qual=0, rd=1, rd_we=1.
- SRAI x3,x4,7 (0x40725193) -> op=101, qual=1, in2[4:0]=7. SLLI with instr[30]=1 (0x40721193) -> illegal=1, rd_we=0.
- AUIPC x5,0x12345 at pc=0x1000 -> in1=0x1000, in2=0x12345000. LUI x6,0xABCDE -> in1=0, in2=0xABCDE000.
- Back-to-back stream of A,B,C,D with out_ready low for 3 cycles -> in_ready drops after 2 entries are buffered; outputs stay stable while stalled; A,B,C,D emerge in order with no duplicates.
- Skid buffer full, then flush_i pulsed together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and neither the buffered nor the flushed entries ever appear; rst_n asserted mid-stream -> outputs go to 0 immediately.
